// File: rtl/pc_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl_pkg
// Shared definitions for the multicycle next-PC sequencer:
//   - state_t    : sequencer state encodings (S_FETCH .. S_INT)
//   - IC_*       : decoded instruction class codes on the iclass port
//   - HANDLER_VEC: exception handler entry address used by the NPC unit
//   - JC_*       : NPC source select codes shared with the NPC unit
// No ports; imported by pc_seq_ctrl and its sub-module.
// ---------------------------------------------------------------------------
package pc_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_INT    = 3'd5
    } state_t;

    localparam logic [2:0] IC_ALU    = 3'd0;
    localparam logic [2:0] IC_LOAD   = 3'd1;
    localparam logic [2:0] IC_STORE  = 3'd2;
    localparam logic [2:0] IC_BRANCH = 3'd3;
    localparam logic [2:0] IC_JUMP   = 3'd4;
    localparam logic [2:0] IC_JLINK  = 3'd5;
    localparam logic [2:0] IC_ERET   = 3'd6;
    localparam logic [2:0] IC_RSVD   = 3'd7;

    localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

    localparam logic [1:0] JC_PC4     = 2'd0;
    localparam logic [1:0] JC_BRANCH  = 2'd1;
    localparam logic [1:0] JC_EPC     = 2'd2;
    localparam logic [1:0] JC_HANDLER = 2'd3;

endpackage

// File: rtl/pc_seq_ctrl_irq_sync.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl_irq_sync
// Two-flop synchroniser for the external interrupt request. With
// IRQ_SYNC=0 the raw request is passed straight through.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset, clears both flops
//   i_irq    in  raw interrupt request (level)
//   o_irq_s  out synchronised (or bypassed) interrupt request
// ---------------------------------------------------------------------------
module pc_seq_ctrl_irq_sync #(
    parameter bit IRQ_SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_irq_s
);

    logic r_meta;
    logic r_sync;

    // The request crosses in from an unrelated domain, so it passes through
    // two flops before anything in the sequencer looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
        end
    end

    // When the source is already synchronous the flops are skipped and
    // simply trimmed away by synthesis.
    assign o_irq_s = IRQ_SYNC ? r_sync : i_irq;

endmodule

// File: rtl/pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl
// Multicycle sequencer for the next-PC datapath. Steps each instruction
// through FETCH/DECODE/EXE/MEM/WB, owns the EXL bit and drives exception
// entry/return strobes. All strobes are combinational decodes of the state
// and inputs; only state and exl are registered.
// Ports:
//   clk, rst              clock (rising) / asynchronous active-high reset
//   iclass[2:0]           decoded instruction class (IC_*)
//   brcond                branch comparison result, valid in S_EXE
//   imem_rdy, dmem_rdy    instruction / data memory ready
//   irq, ie               interrupt request (level) and SR.IE
//   pcwr, turn, irwr      PC write, PC+4 latch, IR write
//   validbr               taken branch select towards NPC
//   regwr, memrd, memwr   register write, data read/write request
//   exlset, exlclr, epcwr exception entry, exception return, EPC write
//   exl                   current exception level bit
//   state[2:0]            current state, for debug
// ---------------------------------------------------------------------------
module pc_seq_ctrl #(
    parameter bit         IRQ_SYNC  = 1'b1,
    parameter logic [2:0] RST_STATE = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] iclass,
    input  logic       brcond,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    input  logic       irq,
    input  logic       ie,
    output logic       pcwr,
    output logic       turn,
    output logic       irwr,
    output logic       validbr,
    output logic       regwr,
    output logic       memrd,
    output logic       memwr,
    output logic       exlset,
    output logic       exlclr,
    output logic       epcwr,
    output logic       exl,
    output logic [2:0] state
);

    import pc_seq_ctrl_pkg::*;

    state_t r_state;
    state_t w_stateNext;
    logic   r_exl;
    logic   w_exlNext;
    logic   w_irqS;
    logic   w_commit;
    logic   w_pcwr;
    logic   w_turn;
    logic   w_irwr;
    logic   w_validbr;
    logic   w_regwr;
    logic   w_memrd;
    logic   w_memwr;
    logic   w_exlset;
    logic   w_exlclr;
    logic   w_epcwr;

    pc_seq_ctrl_irq_sync #(
        .IRQ_SYNC (IRQ_SYNC)
    ) u_irqSync (
        .clk     (clk),
        .rst     (rst),
        .i_irq   (irq),
        .o_irq_s (w_irqS)
    );

    // Next-state and strobe decode. Every path that retires an instruction
    // raises w_commit; the commit check afterwards decides between the next
    // fetch and interrupt entry. The check uses w_exlNext so that an ERET
    // clearing EXL in this cycle lets a pending interrupt in immediately.
    always_comb begin
        w_stateNext = S_FETCH;
        w_exlNext   = r_exl;
        w_commit    = 1'b0;
        w_pcwr      = 1'b0;
        w_turn      = 1'b0;
        w_irwr      = 1'b0;
        w_validbr   = 1'b0;
        w_regwr     = 1'b0;
        w_memrd     = 1'b0;
        w_memwr     = 1'b0;
        w_exlset    = 1'b0;
        w_exlclr    = 1'b0;
        w_epcwr     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwr      = imem_rdy;
                w_turn      = imem_rdy;
                w_stateNext = imem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_stateNext = S_EXE;
            end
            S_EXE: begin
                case (iclass)
                    IC_ALU, IC_JLINK: begin
                        w_stateNext = S_WB;
                    end
                    IC_LOAD, IC_STORE: begin
                        w_stateNext = S_MEM;
                    end
                    IC_BRANCH: begin
                        w_validbr = brcond;
                        w_pcwr    = 1'b1;
                        w_commit  = 1'b1;
                    end
                    IC_ERET: begin
                        w_pcwr   = 1'b1;
                        w_commit = 1'b1;
                        if (r_exl) begin
                            w_exlclr  = 1'b1;
                            w_exlNext = 1'b0;
                        end
                    end
                    default: begin
                        w_pcwr   = 1'b1;
                        w_commit = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_memrd = (iclass == IC_LOAD);
                w_memwr = (iclass == IC_STORE);
                if (!dmem_rdy) begin
                    w_stateNext = S_MEM;
                end else if (iclass == IC_STORE) begin
                    w_pcwr   = 1'b1;
                    w_commit = 1'b1;
                end else begin
                    w_stateNext = S_WB;
                end
            end
            S_WB: begin
                w_regwr  = 1'b1;
                w_pcwr   = 1'b1;
                w_commit = 1'b1;
            end
            S_INT: begin
                w_exlset  = 1'b1;
                w_epcwr   = 1'b1;
                w_pcwr    = 1'b1;
                w_exlNext = 1'b1;
            end
            default: begin
                w_stateNext = S_FETCH;
            end
        endcase
        if (w_commit) begin
            w_stateNext = (w_irqS && ie && !w_exlNext) ? S_INT : S_FETCH;
        end
    end

    // Only the state and the EXL bit are held in flops; reset aborts any
    // instruction in flight and drops the exception level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= state_t'(RST_STATE);
            r_exl   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_exl   <= w_exlNext;
        end
    end

    // Strobes are forced low while reset is held so that a fetch-state
    // decode on imem_rdy cannot leak out during reset.
    assign pcwr    = w_pcwr    & ~rst;
    assign turn    = w_turn    & ~rst;
    assign irwr    = w_irwr    & ~rst;
    assign validbr = w_validbr & ~rst;
    assign regwr   = w_regwr   & ~rst;
    assign memrd   = w_memrd   & ~rst;
    assign memwr   = w_memwr   & ~rst;
    assign exlset  = w_exlset  & ~rst;
    assign exlclr  = w_exlclr  & ~rst;
    assign epcwr   = w_epcwr   & ~rst;
    assign exl     = r_exl;
    assign state   = r_state;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_seq_ctrl
// Directed bench for pc_seq_ctrl (IRQ_SYNC=0). Each stimulus cycle pushes
// its hand-computed expected outputs into a scoreboard queue; a monitor
// pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_pc_seq_ctrl;

    localparam logic [2:0] ALU    = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STORE  = 3'd2;
    localparam logic [2:0] BRANCH = 3'd3;
    localparam logic [2:0] JUMP   = 3'd4;
    localparam logic [2:0] JLINK  = 3'd5;
    localparam logic [2:0] ERET   = 3'd6;

    // Strobe vector bit order: pcwr turn irwr validbr regwr memrd memwr
    // exlset exlclr epcwr
    localparam logic [9:0] B_P  = 10'b10_0000_0000;
    localparam logic [9:0] B_T  = 10'b01_0000_0000;
    localparam logic [9:0] B_I  = 10'b00_1000_0000;
    localparam logic [9:0] B_V  = 10'b00_0100_0000;
    localparam logic [9:0] B_R  = 10'b00_0010_0000;
    localparam logic [9:0] B_MR = 10'b00_0001_0000;
    localparam logic [9:0] B_MW = 10'b00_0000_1000;
    localparam logic [9:0] B_XS = 10'b00_0000_0100;
    localparam logic [9:0] B_XC = 10'b00_0000_0010;
    localparam logic [9:0] B_EW = 10'b00_0000_0001;
    localparam logic [9:0] B_0  = 10'b00_0000_0000;

    typedef struct {
        int         id;
        logic [2:0] st;
        logic [9:0] strb;
        logic       exl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] iclass = 3'd0;
    logic       brcond = 1'b0;
    logic       imem_rdy = 1'b0;
    logic       dmem_rdy = 1'b0;
    logic       irq = 1'b0;
    logic       ie = 1'b0;
    logic       pcwr, turn, irwr, validbr, regwr, memrd, memwr;
    logic       exlset, exlclr, epcwr, exl;
    logic [2:0] state;

    exp_t sbQ[$];
    int   total = 0;
    int   bad = 0;
    int   stepId = 0;

    pc_seq_ctrl #(
        .IRQ_SYNC  (1'b0),
        .RST_STATE (3'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iclass   (iclass),
        .brcond   (brcond),
        .imem_rdy (imem_rdy),
        .dmem_rdy (dmem_rdy),
        .irq      (irq),
        .ie       (ie),
        .pcwr     (pcwr),
        .turn     (turn),
        .irwr     (irwr),
        .validbr  (validbr),
        .regwr    (regwr),
        .memrd    (memrd),
        .memwr    (memwr),
        .exlset   (exlset),
        .exlclr   (exlclr),
        .epcwr    (epcwr),
        .exl      (exl),
        .state    (state)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input int id,
                               input logic [9:0] act, input logic [9:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s step%0d: got %b expected %b", name, id, act, expv);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, records what
    // the DUT must show during that cycle, then waits out the cycle.
    task automatic applyStimulus(input logic iRst, input logic [2:0] ic,
                                 input logic br, input logic imr, input logic dmr,
                                 input logic irqIn, input logic ieIn,
                                 input logic [2:0] eSt, input logic [9:0] eStrb,
                                 input logic eExl);
        exp_t e;
        rst      = iRst;
        iclass   = ic;
        brcond   = br;
        imem_rdy = imr;
        dmem_rdy = dmr;
        irq      = irqIn;
        ie       = ieIn;
        e.id     = stepId;
        e.st     = eSt;
        e.strb   = eStrb;
        e.exl    = eExl;
        stepId++;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // FETCH (rdy high) followed by DECODE for one instruction.
    task automatic fetchDec(input logic [2:0] ic, input logic irqIn,
                            input logic ieIn, input logic eExl);
        applyStimulus(1'b0, ic, 1'b0, 1'b1, 1'b1, irqIn, ieIn, 3'd0, B_T | B_I, eExl);
        applyStimulus(1'b0, ic, 1'b0, 1'b1, 1'b1, irqIn, ieIn, 3'd1, B_0, eExl);
    endtask

    // Monitor: compares the DUT against the oldest scoreboard entry on every
    // falling edge that has an entry waiting.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("state", e.id, {7'd0, state}, {7'd0, e.st});
                checkOutput("strobes", e.id,
                            {pcwr, turn, irwr, validbr, regwr, memrd, memwr,
                             exlset, exlclr, epcwr}, e.strb);
                checkOutput("exl", e.id, {9'd0, exl}, {9'd0, e.exl});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset held with imem_rdy high: nothing may leak out.
        applyStimulus(1'b1, ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, B_0, 1'b0);

        // ALU: 0,1,2,4
        fetchDec(ALU, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_0, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, B_P | B_R, 1'b0);

        // LOAD with dmem_rdy low three cycles in S_MEM
        fetchDec(LOAD, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, B_0, 1'b0);
        repeat (3)
            applyStimulus(1'b0, LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, B_MR, 1'b0);
        applyStimulus(1'b0, LOAD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, B_MR, 1'b0);
        applyStimulus(1'b0, LOAD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, B_P | B_R, 1'b0);

        // BRANCH taken then not taken
        fetchDec(BRANCH, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, BRANCH, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_P | B_V, 1'b0);
        fetchDec(BRANCH, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, BRANCH, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_P, 1'b0);

        // JUMP with irq high but interrupts disabled: no S_INT
        fetchDec(JUMP, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, JUMP, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, B_P, 1'b0);

        // JLINK: 4 cycles ending in WB
        fetchDec(JLINK, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, JLINK, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_0, 1'b0);
        applyStimulus(1'b0, JLINK, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, B_P | B_R, 1'b0);

        // ALU with irq taken at commit
        fetchDec(ALU, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, B_0, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, B_P | B_R, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, B_P | B_XS | B_EW, 1'b0);

        // Second irq ignored while exl=1
        fetchDec(ALU, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, B_0, 1'b1);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, B_P | B_R, 1'b1);

        // ERET with exl=1 and irq still high: straight back into S_INT
        fetchDec(ERET, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, ERET, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, B_P | B_XC, 1'b1);
        applyStimulus(1'b0, ERET, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, B_P | B_XS | B_EW, 1'b0);

        // STORE aborted by reset while waiting in S_MEM
        fetchDec(STORE, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, STORE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, B_0, 1'b1);
        applyStimulus(1'b0, STORE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, B_MW, 1'b1);
        applyStimulus(1'b1, STORE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, B_0, 1'b0);

        // ERET with exl=0 acts as a NOP
        fetchDec(ERET, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ERET, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_P, 1'b0);

        // STORE with memory ready: commit from S_MEM
        fetchDec(STORE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, STORE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_0, 1'b0);
        applyStimulus(1'b0, STORE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, B_P | B_MW, 1'b0);

        // Fetch stall on imem_rdy low
        applyStimulus(1'b0, ALU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, B_0, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, B_0, 1'b0);
        fetchDec(ALU, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, B_0, 1'b0);
        applyStimulus(1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, B_P | B_R, 1'b0);

        repeat (2) @(posedge clk);
        checkOutput("drain", 0, 10'(sbQ.size()), 10'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
